// File: rtl/riscv_alu_seq_pkg.sv
// Shared definitions for the sequential ALU: ctrl encoding, op classes, FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package riscv_alu_seq_pkg;

  // Internal 4-bit ALU control encoding produced by the decoder
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_ADDW = 4'b1001,
    ALU_SUBW = 4'b1010,
    ALU_SLLW = 4'b1011,
    ALU_SRLW = 4'b1100,
    ALU_SRA  = 4'b1101,
    ALU_SRAW = 4'b1110,
    ALU_BAD  = 4'b1111
  } alu_ctrl_e;

  // alu_op class codes coming from the main decoder
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_R   = 3'b010;
  localparam logic [2:0] OP_I   = 3'b011;
  localparam logic [2:0] OP_RW  = 3'b110;
  localparam logic [2:0] OP_IW  = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic is_shift(input alu_ctrl_e c);
    return c inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLW, ALU_SRLW, ALU_SRAW};
  endfunction

  // W ops work on the low 32 bits and sign-extend the 32-bit result
  function automatic logic is_word(input alu_ctrl_e c);
    return c inside {ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW};
  endfunction

  function automatic logic is_left(input alu_ctrl_e c);
    return c inside {ALU_SLL, ALU_SLLW};
  endfunction

  function automatic logic is_arith(input alu_ctrl_e c);
    return c inside {ALU_SRA, ALU_SRAW};
  endfunction

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational {alu_op, func_code} -> 4-bit ALU ctrl decoder; W ops become bad when XLEN==32.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the sequencer samples ctrl only when it accepts a request.
module riscv_alu_decode
  import riscv_alu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0] alu_op,
  input  logic [3:0] func_code,
  output logic [3:0] ctrl
);

  alu_ctrl_e dec;

  // Map op class plus {funct7[5], funct3} onto the internal ctrl encoding
  always_comb begin
    dec = ALU_BAD;
    case (alu_op)
      OP_ADD: dec = ALU_ADD;
      OP_SUB: dec = ALU_SUB;
      OP_R: begin
        // R-type: code is used as-is; only sub and sra may carry funct7[5]
        if (!func_code[3])              dec = alu_ctrl_e'(func_code);
        else if (func_code == 4'b1000)  dec = ALU_SUB;
        else if (func_code == 4'b1101)  dec = ALU_SRA;
        else                            dec = ALU_BAD;
      end
      OP_I: begin
        // I-type: funct7[5] is really immediate bits, so it is ignored except on shifts
        case (func_code)
          4'b0001: dec = ALU_SLL;
          4'b1001: dec = ALU_BAD;
          4'b0101: dec = ALU_SRL;
          4'b1101: dec = ALU_SRA;
          default: dec = alu_ctrl_e'({1'b0, func_code[2:0]});
        endcase
      end
      OP_RW, OP_IW: begin
        case (func_code)
          4'b0000: dec = ALU_ADDW;
          // addiw has no subtract form; bit3 is just immediate there
          4'b1000: dec = (alu_op == OP_RW) ? ALU_SUBW : ALU_ADDW;
          4'b0001: dec = ALU_SLLW;
          4'b0101: dec = ALU_SRLW;
          4'b1101: dec = ALU_SRAW;
          default: dec = ALU_BAD;
        endcase
      end
      default: dec = ALU_BAD;
    endcase
    // RV32 has no W instructions
    if (XLEN == 32 && is_word(dec)) dec = ALU_BAD;
  end

  assign ctrl = dec;

endmodule

// File: rtl/riscv_alu_seq.sv
// Sequential EX-stage ALU: decodes, executes, returns one registered result (RISCV_ALU_FAST_SHIFT_EN selects a barrel shifter).
// Latency: 2 edges accept->out_valid; iterative shifts take 1 + ceil(shamt/SHIFT_STEP) + 1 edges.
// Backpressure: one op in flight; in_ready low while busy, result/illegal held in DONE until out_ready; flush kills.
module riscv_alu_seq
  import riscv_alu_seq_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [3:0]      func_code,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  // Wide enough for any shift amount (0..63) and for SHIFT_STEP up to 64
  localparam int            CW   = 7;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  alu_ctrl_e       ctrl_q, ctrl_d;
  logic [XLEN-1:0] shf_q, shf_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      dec_ctrl;
  logic            sh_op, w_op, sh_left, sh_arith, go_shift;
  logic [CW-1:0]   shamt;
  logic [CW-1:0]   step;
  logic [CW-1:0]   rem_next;
  logic [XLEN-1:0] shf_init;
  logic [XLEN-1:0] shf_step;
  logic [XLEN-1:0] sum, diff;
  logic [XLEN-1:0] exec_res;

  riscv_alu_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .alu_op   (alu_op),
    .func_code(func_code),
    .ctrl     (dec_ctrl)
  );

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // W results keep only the low word and sign-extend it
  function automatic logic [XLEN-1:0] finish_res(input logic [XLEN-1:0] v, input logic w);
    return w ? sext32(v[31:0]) : v;
  endfunction

  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v, input logic [CW-1:0] n,
                                               input logic left, input logic arith);
    if (left)       return v << n;
    else if (arith) return $signed(v) >>> n;
    else            return v >> n;
  endfunction

  assign sh_op    = is_shift(ctrl_q);
  assign w_op     = is_word(ctrl_q);
  assign sh_left  = is_left(ctrl_q);
  assign sh_arith = is_arith(ctrl_q);

  // Shift amount and shifter operand derived from the latched request
  always_comb begin
    shamt = '0;
    if (XLEN == 64 && !w_op) shamt = CW'(b_q[5:0]);
    else                     shamt = CW'(b_q[4:0]);
    // Right W shifts must see only the low word, extended the way the shift fills
    shf_init = a_q;
    if (ctrl_q == ALU_SRLW) begin
      shf_init       = '0;
      shf_init[31:0] = a_q[31:0];
    end else if (ctrl_q == ALU_SRAW) begin
      shf_init = sext32(a_q[31:0]);
    end
  end

  // Single-cycle result for everything the EXEC state can finish on its own
  always_comb begin
    sum      = a_q + b_q;
    diff     = a_q - b_q;
    exec_res = '0;
    case (ctrl_q)
      ALU_ADD:  exec_res    = sum;
      ALU_SUB:  exec_res    = diff;
      ALU_SLT:  exec_res[0] = $signed(a_q) < $signed(b_q);
      ALU_SLTU: exec_res[0] = a_q < b_q;
      ALU_XOR:  exec_res    = a_q ^ b_q;
      ALU_OR:   exec_res    = a_q | b_q;
      ALU_AND:  exec_res    = a_q & b_q;
      ALU_ADDW: exec_res    = sext32(sum[31:0]);
      ALU_SUBW: exec_res    = sext32(diff[31:0]);
      default: begin
`ifdef RISCV_ALU_FAST_SHIFT_EN
        if (sh_op) exec_res = finish_res(shift_by(shf_init, shamt, sh_left, sh_arith), w_op);
`else
        // Only zero-amount shifts finish in EXEC in the iterative build
        if (sh_op) exec_res = finish_res(shf_init, w_op);
`endif
      end
    endcase
  end

  // Decide whether EXEC hands off to the iterative shifter
  always_comb begin
`ifdef RISCV_ALU_FAST_SHIFT_EN
    go_shift = 1'b0;
`else
    go_shift = sh_op && (shamt != '0);
`endif
  end

  // Next-state and datapath update; flush overrides every transition
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    shf_d     = shf_q;
    rem_d     = rem_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    step      = (rem_q < STEP) ? rem_q : STEP;
    shf_step  = shift_by(shf_q, step, sh_left, sh_arith);
    rem_next  = rem_q - step;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = src_a;
          b_d     = src_b;
          ctrl_d  = alu_ctrl_e'(dec_ctrl);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (go_shift) begin
          shf_d   = shf_init;
          rem_d   = shamt;
          state_d = ST_SHIFT;
        end else begin
          result_d  = exec_res;
          illegal_d = (ctrl_q == ALU_BAD);
          state_d   = ST_DONE;
        end
      end
      ST_SHIFT: begin
        shf_d = shf_step;
        rem_d = rem_next;
        if (rem_next == '0) begin
          result_d  = finish_res(shf_step, w_op);
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand, shifter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= ALU_ADD;
      shf_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      shf_q     <= shf_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Self-checking bench for riscv_alu_seq (XLEN=64, SHIFT_STEP=4): directed cases plus random traffic.
// A countdown/queue-free behavioural model predicts out_valid, in_ready, result and illegal every cycle.
// Follows RISCV_ALU_FAST_SHIFT_EN for the expected shift latency.
module tb_riscv_alu_seq;

  localparam int XLEN = 64;
  localparam int STEP = 4;
`ifdef RISCV_ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = 3'd0;
  logic [3:0]  func_code = 4'd0;
  logic [63:0] src_a = 64'd0;
  logic [63:0] src_b = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  bit rnd_en = 1'b0;

  always #5 clk = ~clk;

  riscv_alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .func_code(func_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .illegal  (illegal)
  );

  // ---------------- reference model ----------------
  typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
                M_ADDW, M_SUBW, M_SLLW, M_SRLW, M_SRAW, M_BAD} mop_e;

  function automatic mop_e ref_decode(input logic [2:0] op, input logic [3:0] fc);
    mop_e m;
    mop_e f3 [8];
    f3 = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
    m = M_BAD;
    if (op == 3'b000) m = M_ADD;
    else if (op == 3'b001) m = M_SUB;
    else if (op == 3'b010) begin
      if (fc[3] == 1'b0) m = f3[fc[2:0]];
      else if (fc == 4'b1000) m = M_SUB;
      else if (fc == 4'b1101) m = M_SRA;
    end else if (op == 3'b011) begin
      if (fc == 4'b1001) m = M_BAD;
      else if (fc == 4'b1101) m = M_SRA;
      else m = f3[fc[2:0]];
    end else if (op == 3'b110 || op == 3'b111) begin
      if (fc == 4'b0000) m = M_ADDW;
      else if (fc == 4'b1000) m = (op == 3'b110) ? M_SUBW : M_ADDW;
      else if (fc == 4'b0001) m = M_SLLW;
      else if (fc == 4'b0101) m = M_SRLW;
      else if (fc == 4'b1101) m = M_SRAW;
    end
    if (XLEN == 32 && m inside {M_ADDW, M_SUBW, M_SLLW, M_SRLW, M_SRAW}) m = M_BAD;
    return m;
  endfunction

  function automatic void ref_alu(input logic [2:0] op, input logic [3:0] fc,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output bit ill, output int lat);
    mop_e        m;
    int          sh;
    logic [31:0] w;
    m   = ref_decode(op, fc);
    r   = 64'd0;
    ill = 1'b0;
    w   = 32'd0;
    sh  = (m inside {M_SLLW, M_SRLW, M_SRAW}) ? int'(b[4:0]) : int'(b[5:0]);
    case (m)
      M_ADD:  r = a + b;
      M_SUB:  r = a - b;
      M_SLT:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      M_SLTU: r = (a < b) ? 64'd1 : 64'd0;
      M_XOR:  r = a ^ b;
      M_OR:   r = a | b;
      M_AND:  r = a & b;
      M_SLL:  r = a << sh;
      M_SRL:  r = a >> sh;
      M_SRA:  r = $signed(a) >>> sh;
      M_ADDW: begin w = a[31:0] + b[31:0];            r = {{32{w[31]}}, w}; end
      M_SUBW: begin w = a[31:0] - b[31:0];            r = {{32{w[31]}}, w}; end
      M_SLLW: begin w = a[31:0] << sh;                r = {{32{w[31]}}, w}; end
      M_SRLW: begin w = a[31:0] >> sh;                r = {{32{w[31]}}, w}; end
      M_SRAW: begin w = $signed(a[31:0]) >>> sh;      r = {{32{w[31]}}, w}; end
      default: ill = 1'b1;
    endcase
    lat = 2;
    if (!FAST && m inside {M_SLL, M_SRL, M_SRA, M_SLLW, M_SRLW, M_SRAW})
      lat = 2 + (sh + STEP - 1) / STEP;
  endfunction

  // Model: idle / counting down to valid / holding a result
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  int          m_lat  = 0;
  logic [63:0] m_res  = 64'd0;
  bit          m_ill  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
    end else if (flush) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (in_valid) begin
      ref_alu(alu_op, func_code, src_a, src_b, m_res, m_ill, m_lat);
      m_cnt  = m_lat - 1;
      m_busy = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_done));
      chk("in_ready", 64'(in_ready), 64'(!m_busy && !m_done && !flush));
      if (m_done) begin
        chk("result", result, m_res);
        chk("illegal", 64'(illegal), 64'(m_ill));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) begin
      flush     = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < 70);
    end
  endtask

  // Present a request and hold it until accepted; returns one cycle past the accept edge
  task automatic issue(input logic [2:0] op, input logic [3:0] fc,
                       input logic [63:0] a, input logic [63:0] b);
    bit acc;
    int waits;
    acc       = 1'b0;
    waits     = 0;
    alu_op    = op;
    func_code = fc;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    while (!acc && waits < 400) begin
      @(negedge clk);
      acc = in_ready;
      waits++;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: request never accepted after %0d cycles", waits);
    end
  endtask

  // Count edges from the accept edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 400);
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: out_valid not seen within %0d cycles", n);
    end
  endtask

  logic [2:0] ops [10] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b011, 3'b011,
                           3'b110, 3'b111, 3'b100, 3'b101};

  initial begin
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    tick();

    // add 5 + -7
    issue(3'b000, 4'b0000, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9);
    wait_valid(n);
    chk("add_latency", 64'(n), 64'd2);
    chk("add_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_illegal", 64'(illegal), 64'd0);
    tick();

    // sra by 37, ten SHIFT cycles
    issue(3'b010, 4'b1101, 64'h8000_0000_0000_0000, 64'd37);
    wait_valid(n);
    chk("sra_latency", 64'(n), FAST ? 64'd2 : 64'd12);
    chk("sra_result", result, 64'hFFFF_FFFF_FC00_0000);
    tick();

    // addw overflow into the sign bit
    issue(3'b110, 4'b0000, 64'h0000_0000_7FFF_FFFF, 64'd1);
    wait_valid(n);
    chk("addw_result", result, 64'hFFFF_FFFF_8000_0000);
    chk("addw_illegal", 64'(illegal), 64'd0);
    tick();

    // reset asserted in the middle of a long shift
    issue(3'b010, 4'b0001, 64'd1, 64'd63);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // backpressure on an illegal op
    out_ready = 1'b0;
    issue(3'b011, 4'b1001, {$urandom, $urandom}, {$urandom, $urandom});
    wait_valid(n);
    chk("bad_latency", 64'(n), 64'd2);
    chk("bad_result", result, 64'd0);
    chk("bad_illegal", 64'(illegal), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_result_held", result, 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_hs", 64'(out_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("bp_valid_after_hs", 64'(out_valid), 64'd0);
    tick();

    // flush while shifting, then a request the very next cycle
    issue(3'b010, 4'b0101, 64'hF0F0_1234_5678_9ABC, 64'd40);
    repeat (4) @(negedge clk);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", 64'(in_ready), 64'd0);
    tick();
    flush     = 1'b0;
    alu_op    = 3'b000;
    func_code = 4'b0000;
    src_a     = 64'd3;
    src_b     = 64'd4;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("flush_shift_valid", 64'(out_valid), 64'd0);
    chk("ready_after_flush", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("post_flush_latency", 64'(n), 64'd2);
    chk("post_flush_result", result, 64'd7);
    tick();

    // flush while holding a result in DONE
    out_ready = 1'b0;
    issue(3'b000, 4'b0000, 64'd1, 64'd2);
    wait_valid(n);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_done_hold", 64'(out_valid), 64'd1);
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    tick();

    // random traffic with random backpressure and flushes
    rnd_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [63:0] a;
      logic [63:0] b;
      int          g;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) b[5:0] = 6'd0;
      issue(ops[$urandom_range(0, 9)], 4'($urandom_range(0, 15)), a, b);
      g = $urandom_range(0, 2);
      repeat (g) tick();
    end
    rnd_en    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && (m_busy || m_done); i++) tick();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
